// File: rtl/kernel_nios2_cpu_pkg.sv
// Shared Nios II kernel definitions: multiplier half-word width and combine-FSM encoding.
// KERNEL_MULT_COMBINE_HI_EN adds the SUMHI state used by the high-word (mulxuu) path.
package kernel_nios2_cpu_pkg;

    localparam int MUL_HALF_W = 16;
    localparam int MUL_W      = 2 * MUL_HALF_W;

`ifdef KERNEL_MULT_COMBINE_HI_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SUM1  = 3'd1,
        ST_SUM2  = 3'd2,
        ST_DONE  = 3'd3,
        ST_SUMHI = 3'd4
    } mul_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM1 = 2'd1,
        ST_SUM2 = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;
`endif

endpackage : kernel_nios2_cpu_pkg

// File: rtl/kernel_nios2_cpu_mult_combine.sv
// Combines 16x16 partial products into the 32-bit product word over a short FSM.
// Define KERNEL_MULT_COMBINE_HI_EN to add p4/E_mul_hi and the 64-bit high-word path.
module kernel_nios2_cpu_mult_combine
    import kernel_nios2_cpu_pkg::*;
#(
    parameter bit ZERO_SHORTCUT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [MUL_W-1:0] M_mul_cell_p1,
    input  logic [MUL_W-1:0] M_mul_cell_p2,
    input  logic [MUL_W-1:0] M_mul_cell_p3,
`ifdef KERNEL_MULT_COMBINE_HI_EN
    input  logic [MUL_W-1:0] M_mul_cell_p4,
    input  logic             E_mul_hi,
`endif
    input  logic             M_mul_start,
    input  logic             W_mul_ready,
    output logic [MUL_W-1:0] W_mul_result,
    output logic             W_mul_valid,
    output logic             M_mul_busy
);

`ifdef KERNEL_MULT_COMBINE_HI_EN
    localparam int ACC_W = 2 * MUL_W;
`else
    localparam int ACC_W = MUL_W;
`endif

    mul_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [MUL_W-1:0] p1_q, p1_d;
    logic [MUL_W-1:0] p2_q, p2_d;
    logic [MUL_W-1:0] p3_q, p3_d;
    logic             all_zero;

`ifdef KERNEL_MULT_COMBINE_HI_EN
    logic [MUL_W-1:0] p4_q, p4_d;
    logic             hi_q, hi_d;

    // p4 only matters for a high-word request, but a zero shortcut must never skip a nonzero term.
    assign all_zero = ~|{M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4};
`else
    assign all_zero = ~|{M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3};
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
`ifdef KERNEL_MULT_COMBINE_HI_EN
        p4_d    = p4_q;
        hi_d    = hi_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (M_mul_start) begin
                    p1_d = M_mul_cell_p1;
                    p2_d = M_mul_cell_p2;
                    p3_d = M_mul_cell_p3;
`ifdef KERNEL_MULT_COMBINE_HI_EN
                    p4_d = M_mul_cell_p4;
                    hi_d = E_mul_hi;
`endif
                    if (ZERO_SHORTCUT && all_zero) begin
                        acc_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SUM1;
                    end
                end
            end
            // In the 32-bit build the shift drops p2/p3[31:16]; the 64-bit build keeps them.
            ST_SUM1: begin
                acc_d   = ACC_W'(p1_q) + (ACC_W'(p2_q) << MUL_HALF_W);
                state_d = ST_SUM2;
            end
            ST_SUM2: begin
                acc_d   = acc_q + (ACC_W'(p3_q) << MUL_HALF_W);
`ifdef KERNEL_MULT_COMBINE_HI_EN
                state_d = hi_q ? ST_SUMHI : ST_DONE;
`else
                state_d = ST_DONE;
`endif
            end
`ifdef KERNEL_MULT_COMBINE_HI_EN
            ST_SUMHI: begin
                acc_d   = acc_q + (ACC_W'(p4_q) << MUL_W);
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (W_mul_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
`ifdef KERNEL_MULT_COMBINE_HI_EN
            p4_q    <= '0;
            hi_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
`ifdef KERNEL_MULT_COMBINE_HI_EN
            p4_q    <= p4_d;
            hi_q    <= hi_d;
`endif
        end
    end

    assign W_mul_valid = (state_q == ST_DONE);
    assign M_mul_busy  = (state_q != ST_IDLE);

`ifdef KERNEL_MULT_COMBINE_HI_EN
    assign W_mul_result = !W_mul_valid ? '0
                        : hi_q ? acc_q[ACC_W-1:MUL_W] : acc_q[MUL_W-1:0];
`else
    assign W_mul_result = W_mul_valid ? acc_q : '0;
`endif

endmodule : kernel_nios2_cpu_mult_combine

// File: tb/tb_kernel_nios2_cpu_mult_combine.sv
// Directed bench for kernel_nios2_cpu_mult_combine; a second instance runs with ZERO_SHORTCUT=1.
// The high-word scenario is only exercised when KERNEL_MULT_COMBINE_HI_EN is defined.
module tb_kernel_nios2_cpu_mult_combine;

    logic        clk;
    logic        reset_n;
    logic [31:0] p1, p2, p3;
`ifdef KERNEL_MULT_COMBINE_HI_EN
    logic [31:0] p4;
    logic        hi;
`endif
    logic        start;
    logic        ready;
    logic [31:0] result,   z_result;
    logic        valid,    z_valid;
    logic        busy,     z_busy;

    int total = 0;
    int bad   = 0;

    kernel_nios2_cpu_mult_combine #(.ZERO_SHORTCUT(1'b0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .M_mul_cell_p1(p1),
        .M_mul_cell_p2(p2),
        .M_mul_cell_p3(p3),
`ifdef KERNEL_MULT_COMBINE_HI_EN
        .M_mul_cell_p4(p4),
        .E_mul_hi     (hi),
`endif
        .M_mul_start  (start),
        .W_mul_ready  (ready),
        .W_mul_result (result),
        .W_mul_valid  (valid),
        .M_mul_busy   (busy)
    );

    kernel_nios2_cpu_mult_combine #(.ZERO_SHORTCUT(1'b1)) dut_z (
        .clk          (clk),
        .reset_n      (reset_n),
        .M_mul_cell_p1(p1),
        .M_mul_cell_p2(p2),
        .M_mul_cell_p3(p3),
`ifdef KERNEL_MULT_COMBINE_HI_EN
        .M_mul_cell_p4(p4),
        .E_mul_hi     (hi),
`endif
        .M_mul_start  (start),
        .W_mul_ready  (ready),
        .W_mul_result (z_result),
        .W_mul_valid  (z_valid),
        .M_mul_busy   (z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        p1 = a;
        p2 = b;
        p3 = c;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        set_p(32'h0, 32'h0, 32'h0);
`ifdef KERNEL_MULT_COMBINE_HI_EN
        p4 = 32'h0;
        hi = 1'b0;
`endif
        #3;
        check("reset_valid",  {31'd0, valid}, 32'd0);
        check("reset_result", result,         32'd0);
        check("reset_busy",   {31'd0, busy},  32'd0);
        #14;
        reset_n = 1'b1;
        tick();

        // Basic product 0x0002_0003 * 0x0004_0005; inputs scrambled after the start pulse.
        set_p(32'h0000_000F, 32'h0000_000C, 32'h0000_000A);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_p(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check("basic_busy_c1",  {31'd0, busy},  32'd1);
        check("basic_valid_c1", {31'd0, valid}, 32'd0);
        check("basic_result_c1", result,        32'd0);
        tick();
        check("basic_valid_c2", {31'd0, valid}, 32'd0);
        tick();
        check("basic_valid_c3", {31'd0, valid}, 32'd1);
        check("basic_result",   result,         32'h0016_000F);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("basic_release_valid",  {31'd0, valid}, 32'd0);
        check("basic_release_result", result,         32'd0);
        check("basic_release_busy",   {31'd0, busy},  32'd0);

        // Wrap: 0xFFFF_FFFF squared, low word only.
        set_p(32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("wrap_valid",  {31'd0, valid}, 32'd1);
        check("wrap_result", result,         32'h0000_0001);
        ready = 1'b1;
        tick();
        ready = 1'b0;

`ifdef KERNEL_MULT_COMBINE_HI_EN
        // High word of 0xFFFF_FFFF squared, latency 4.
        set_p(32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001);
        p4    = 32'hFFFE_0001;
        hi    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        hi    = 1'b0;
        p4    = 32'h0;
        tick();
        tick();
        check("hi_valid_c3", {31'd0, valid}, 32'd0);
        tick();
        check("hi_valid_c4", {31'd0, valid}, 32'd1);
        check("hi_result",   result,         32'hFFFF_FFFE);
        ready = 1'b1;
        tick();
        ready = 1'b0;
`endif

        // Stall in DONE for 5 cycles with a stray start pulse mid-stall.
        set_p(32'h1234_5678, 32'h0000_0001, 32'h0000_0002);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("stall_valid_first", {31'd0, valid}, 32'd1);
        check("stall_result_first", result,        32'h1237_5678);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            if (i == 2) set_p(32'h0000_0005, 32'h0000_0006, 32'h0000_0007);
            tick();
            check($sformatf("stall_valid_%0d", i),  {31'd0, valid}, 32'd1);
            check($sformatf("stall_result_%0d", i), result,         32'h1237_5678);
        end
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        check("done_start_ignored_busy", {31'd0, busy}, 32'd0);
        tick();
        check("done_start_ignored_busy2", {31'd0, busy},  32'd0);
        check("done_start_ignored_valid", {31'd0, valid}, 32'd0);

        // Reset while in SUM2.
        set_p(32'h0000_1111, 32'h0000_2222, 32'h0000_3333);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_valid",  {31'd0, valid}, 32'd0);
        check("midreset_result", result,         32'd0);
        check("midreset_busy",   {31'd0, busy},  32'd0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_reset_valid_%0d", i), {31'd0, valid}, 32'd0);
            check($sformatf("post_reset_busy_%0d", i),  {31'd0, busy},  32'd0);
        end

        // All-zero products: shortcut instance finishes after 1 cycle, normal one after 3.
        set_p(32'h0, 32'h0, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_sc_valid_c1",  {31'd0, z_valid}, 32'd1);
        check("zero_sc_result_c1", z_result,         32'd0);
        check("zero_valid_c1",     {31'd0, valid},   32'd0);
        tick();
        check("zero_valid_c2", {31'd0, valid}, 32'd0);
        tick();
        check("zero_valid_c3",  {31'd0, valid},   32'd1);
        check("zero_result_c3", result,           32'd0);
        check("zero_sc_hold",   {31'd0, z_valid}, 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("zero_sc_release_busy", {31'd0, z_busy}, 32'd0);

        // Back-to-back: second start on the cycle after the first result is accepted.
        set_p(32'h0000_0100, 32'h0000_0002, 32'h0000_0003);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("b2b_first_valid",  {31'd0, valid}, 32'd1);
        check("b2b_first_result", result,         32'h0005_0100);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        set_p(32'h0000_0007, 32'h0000_0000, 32'h0000_0001);
        start = 1'b1;
        check("b2b_gap_valid", {31'd0, valid}, 32'd0);
        tick();
        start = 1'b0;
        check("b2b_c2_valid", {31'd0, valid}, 32'd0);
        tick();
        check("b2b_c3_valid", {31'd0, valid}, 32'd0);
        tick();
        check("b2b_second_valid",  {31'd0, valid}, 32'd1);
        check("b2b_second_result", result,         32'h0001_0007);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("b2b_final_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_kernel_nios2_cpu_mult_combine

// File: doc/kernel_nios2_cpu_mult_combine.md
KERNEL_NIOS2_CPU_MULT_COMBINE -- requirements
Module: kernel_nios2_cpu_mult_combine

Interface
REQ-001 SHALL have parameter ZERO_SHORTCUT, default 0; when 1, an all-zero partial-product set skips summation.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port M_mul_cell_p1, input, 32, product src1[15:0]*src2[15:0].
REQ-005 SHALL have port M_mul_cell_p2, input, 32, product src1[15:0]*src2[31:16].
REQ-006 SHALL have port M_mul_cell_p3, input, 32, product src1[31:16]*src2[15:0].
REQ-007 SHALL have port M_mul_start, input, 1, one-cycle pulse: p1..p3 valid this cycle.
REQ-008 SHALL have port W_mul_ready, input, 1, consumer accepts the result.
REQ-009 SHALL have port W_mul_result, output, 32, assembled product word.
REQ-010 SHALL have port W_mul_valid, output, 1, W_mul_result valid.
REQ-011 SHALL have port M_mul_busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SUM1, SUM2, DONE; SUMHI is added only under REQ-024.
REQ-013 IDLE with M_mul_start=1 SHALL capture p1..p3 into internal registers and go to SUM1.
REQ-014 SUM1 SHALL set acc = p1 + {p2[15:0],16'h0} (mod 2^32) and go to SUM2.
REQ-015 SUM2 SHALL set acc = acc + {p3[15:0],16'h0} (mod 2^32) and go to DONE; carries beyond bit 31 are discarded.
REQ-016 DONE SHALL drive W_mul_valid=1 and W_mul_result=acc, holding both stable until W_mul_ready=1; on that cycle the FSM SHALL go to IDLE.
REQ-017 Latency SHALL be exactly 3 cycles: start in cycle N gives W_mul_valid in cycle N+3.
REQ-018 M_mul_start while busy (including DONE with W_mul_ready=1) SHALL be ignored: no capture and no state change.
REQ-019 With ZERO_SHORTCUT=1 and captured p1|p2|p3==0, IDLE SHALL go directly to DONE with acc=0 (latency 1).
REQ-020 W_mul_result SHALL be 0 whenever W_mul_valid=0.

Reset
REQ-021 reset_n low SHALL asynchronously force state to IDLE, acc and captured registers to 0, W_mul_valid=0, W_mul_result=0, M_mul_busy=0.
REQ-022 Reset asserted mid-operation SHALL abort the operation and produce no result after reset release.

Configuration
REQ-023 Macro KERNEL_MULT_COMBINE_HI_EN SHALL select the high-word (mulxuu) feature.
REQ-024 With the macro defined, the block SHALL add input M_mul_cell_p4 (32 bits, src1[31:16]*src2[31:16]) and input E_mul_hi (1 bit, captured at start), and SHALL use a 64-bit accumulator. It SHALL compute p1 + ((p2+p3)<<16) + (p4<<32). When E_mul_hi=1, SUMHI SHALL follow SUM2 and output acc[63:32] with latency 4; when E_mul_hi=0, behaviour SHALL be per REQ-017.
REQ-025 Without the macro, the p4 and E_mul_hi ports and SUMHI SHALL be absent, and behaviour SHALL be per REQ-012..REQ-020.

Structure
REQ-026 The FSM state encoding typedef and the constant MUL_HALF_W=16 SHALL live in the shared kernel_nios2_cpu package.
REQ-027 The block SHALL have no sub-modules; the accumulator adder SHALL be inline.

Verification
REQ-028 Test: src1=0x0002_0003, src2=0x0004_0005 (p1=0xF, p2=0xC, p3=0xA), start at cycle 0 -> W_mul_valid at cycle 3 with W_mul_result=0x0016_000F.
REQ-029 Test: p1=p2=p3=0xFFFE_0001 -> W_mul_result=0x0000_0001 (wrap). With HI_EN, p4=0xFFFE_0001 and E_mul_hi=1 -> 0xFFFF_FFFE at latency 4.
REQ-030 Test: W_mul_ready held low for 5 cycles in DONE -> W_mul_valid and W_mul_result stay stable; a start pulse during DONE is ignored.
REQ-031 Test: reset_n low during SUM2 -> all outputs 0 immediately; W_mul_valid stays 0 for 4 cycles after release.
REQ-032 Test: ZERO_SHORTCUT=1 with all-zero products -> W_mul_valid=1, result 0x0 at cycle 1; ZERO_SHORTCUT=0 -> same result at cycle 3.
REQ-033 Test: back-to-back operation with W_mul_ready=1 in DONE and a new start the next cycle -> second result exactly 4 cycles after the first.
